// File: rtl/flag_branch_resolver_pkg.sv
// Shared opcode constants, CCR bit positions and resolver FSM state type.
// The ALU and the control unit both import this so encodings stay in one place.
package flag_branch_resolver_pkg;

    // Opcodes the resolver decodes; anything else is a plain data op.
    localparam int unsigned OP_NOP = 0;
    localparam int unsigned OP_JMP = 16;
    localparam int unsigned OP_JSR = 17;
    localparam int unsigned OP_RTS = 18;
    localparam int unsigned OP_BEQ = 39;
    localparam int unsigned OP_BNE = 40;
    localparam int unsigned OP_BLT = 41;
    localparam int unsigned OP_BRA = 64;
    localparam int unsigned OP_BSR = 65;

    // Condition Control Register layout (bit 5 and bits above 7 read as zero).
    localparam int CCR_C      = 0;
    localparam int CCR_N      = 1;
    localparam int CCR_V      = 2;
    localparam int CCR_Z      = 3;
    localparam int CCR_INR    = 4;
    localparam int CCR_NOP    = 6;
    localparam int CCR_STKERR = 7;
    localparam int CCR_W      = 8;
    localparam int CCR_OUT_W  = 32;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } fsm_state_t;

    // Arrange the ALU flag wires into CCR[4:0] order.
    function automatic logic [4:0] pack_flags(
        input logic c,
        input logic n,
        input logic v,
        input logic z,
        input logic inr
    );
        logic [4:0] f;
        f          = '0;
        f[CCR_C]   = c;
        f[CCR_N]   = n;
        f[CCR_V]   = v;
        f[CCR_Z]   = z;
        f[CCR_INR] = inr;
        return f;
    endfunction

endpackage

// File: rtl/flag_branch_resolver_return_addr_stack.sv
// Return-address stack: LIFO of DATA_W entries with a saturating occupancy count.
// The top exposes the current top entry combinationally so RTS can redirect
// in the same cycle it pops.
module return_addr_stack #(
    parameter int DATA_W    = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] top_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [DATA_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  sp;
    logic [PTR_W-1:0]  top_idx;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(RAS_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty & ~push;
    // sp points at the next free slot; the wrap modulo RAS_DEPTH is implicit in PTR_W.
    assign top_idx  = sp - 1'b1;
    assign top_data = mem[top_idx];

    // Stack pointer and occupancy; a push into a full stack is dropped here.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp    <= '0;
            count <= '0;
        end else if (do_push) begin
            sp    <= sp + 1'b1;
            count <= count + 1'b1;
        end else if (do_pop) begin
            sp    <= sp - 1'b1;
            count <= count - 1'b1;
        end
    end

    // Entry storage; contents are don't-care until pushed so no reset is needed.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[sp] <= push_data;
        end
    end

endmodule

// File: rtl/flag_branch_resolver.sv
// Flag/branch resolver: captures ALU flags into the CCR, resolves control-flow
// ops into a registered PC redirect and owns the return-address stack.
module flag_branch_resolver
    import flag_branch_resolver_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Op_Valid,
    output logic              Op_Ready,
    input  logic [DATA_W-1:0] ALU_Op,
    input  logic              NOP_FLAG,
    input  logic              INR_FLAG,
    input  logic              ZERO_FLAG,
    input  logic              OVERFLOW_FLAG,
    input  logic              NEGATIVE_FLAG,
    input  logic              CARRY_FLAG,
    input  logic [DATA_W-1:0] PC_Plus,
    input  logic [DATA_W-1:0] Target,
    output logic [31:0]       CCR_Out,
    output logic              Redirect_Valid,
    input  logic              Redirect_Ready,
    output logic [DATA_W-1:0] Redirect_PC
);

    fsm_state_t        state;
    fsm_state_t        next_state;
    logic [CCR_W-1:0]  ccr;

    logic              accept;
    logic              live;
    logic              is_nop_op;
    logic              is_jmp;
    logic              is_jsr;
    logic              is_rts;
    logic              is_beq;
    logic              is_bne;
    logic              is_blt;
    logic              is_bra;
    logic              is_bsr;
    logic              is_call;
    logic              flags_hold;
    logic              cond_taken;
    logic              take;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_err;
    logic              stk_full;
    logic              stk_empty;
    logic [DATA_W-1:0] stk_top;
    logic [DATA_W-1:0] redirect_target;

    function automatic logic op_is(input logic [DATA_W-1:0] op, input int unsigned code);
        return op == DATA_W'(code);
    endfunction

    // Handshakes: the resolver only takes new work while no redirect is outstanding.
    assign Op_Ready       = (state == ST_IDLE);
    assign Redirect_Valid = (state == ST_REDIRECT);
    assign accept         = Op_Valid & Op_Ready;
    // A NOP-flagged op only marks the CCR; it never branches or touches the stack.
    assign live           = accept & ~NOP_FLAG;

    assign is_nop_op = op_is(ALU_Op, OP_NOP);
    assign is_jmp    = op_is(ALU_Op, OP_JMP);
    assign is_jsr    = op_is(ALU_Op, OP_JSR);
    assign is_rts    = op_is(ALU_Op, OP_RTS);
    assign is_beq    = op_is(ALU_Op, OP_BEQ);
    assign is_bne    = op_is(ALU_Op, OP_BNE);
    assign is_blt    = op_is(ALU_Op, OP_BLT);
    assign is_bra    = op_is(ALU_Op, OP_BRA);
    assign is_bsr    = op_is(ALU_Op, OP_BSR);
    assign is_call   = is_jsr | is_bsr;

    // Unconditional control ops and NOP leave the arithmetic flags untouched.
    assign flags_hold = is_nop_op | is_jmp | is_jsr | is_rts | is_bra | is_bsr;

    // Conditions look at the live flag inputs, not the stored CCR.
    assign cond_taken = (is_beq & ZERO_FLAG)
                      | (is_bne & ~ZERO_FLAG)
                      | (is_blt & NEGATIVE_FLAG)
                      | is_jmp | is_bra | is_call
                      | (is_rts & ~stk_empty);

    assign take     = live & cond_taken;
    assign stk_push = live & is_call;
    assign stk_pop  = live & is_rts;
    // Overflowing calls still redirect; underflowing returns do not.
    assign stk_err  = live & ((is_call & stk_full) | (is_rts & stk_empty));

    assign redirect_target = is_rts ? stk_top : Target;

    return_addr_stack #(
        .DATA_W    (DATA_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (Clock),
        .rst       (Reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (PC_Plus),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // FSM state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state: enter REDIRECT on a taken op, leave once fetch accepts it.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (take) begin
                    next_state = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (Redirect_Ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Redirect PC is captured on the taken op and held through the REDIRECT state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Redirect_PC <= '0;
        end else if (take) begin
            Redirect_PC <= redirect_target;
        end
    end

    // CCR update on each accepted op; STKERR is sticky until reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ccr <= '0;
        end else if (accept) begin
            if (NOP_FLAG) begin
                ccr[CCR_NOP] <= 1'b1;
            end else begin
                ccr[CCR_NOP] <= 1'b0;
                if (!flags_hold) begin
                    ccr[CCR_INR:CCR_C] <= pack_flags(CARRY_FLAG, NEGATIVE_FLAG,
                                                     OVERFLOW_FLAG, ZERO_FLAG, INR_FLAG);
                end
                if (stk_err) begin
                    ccr[CCR_STKERR] <= 1'b1;
                end
            end
        end
    end

    assign CCR_Out = {{(CCR_OUT_W - CCR_W){1'b0}}, ccr};

endmodule

// File: tb/tb_flag_branch_resolver.sv
// Scoreboard bench for flag_branch_resolver: a driver issues ops and pushes the
// reference model's expected CCR/redirect; a monitor pops and compares on each
// observed acceptance and tracks redirect state between acceptances.
module tb_flag_branch_resolver;

    localparam int DATA_W    = 32;
    localparam int RAS_DEPTH = 8;

    logic              Clock;
    logic              Reset;
    logic              Op_Valid;
    logic              Op_Ready;
    logic [DATA_W-1:0] ALU_Op;
    logic              NOP_FLAG;
    logic              INR_FLAG;
    logic              ZERO_FLAG;
    logic              OVERFLOW_FLAG;
    logic              NEGATIVE_FLAG;
    logic              CARRY_FLAG;
    logic [DATA_W-1:0] PC_Plus;
    logic [DATA_W-1:0] Target;
    logic [31:0]       CCR_Out;
    logic              Redirect_Valid;
    logic              Redirect_Ready;
    logic [DATA_W-1:0] Redirect_PC;

    flag_branch_resolver #(
        .DATA_W    (DATA_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Op_Valid       (Op_Valid),
        .Op_Ready       (Op_Ready),
        .ALU_Op         (ALU_Op),
        .NOP_FLAG       (NOP_FLAG),
        .INR_FLAG       (INR_FLAG),
        .ZERO_FLAG      (ZERO_FLAG),
        .OVERFLOW_FLAG  (OVERFLOW_FLAG),
        .NEGATIVE_FLAG  (NEGATIVE_FLAG),
        .CARRY_FLAG     (CARRY_FLAG),
        .PC_Plus        (PC_Plus),
        .Target         (Target),
        .CCR_Out        (CCR_Out),
        .Redirect_Valid (Redirect_Valid),
        .Redirect_Ready (Redirect_Ready),
        .Redirect_PC    (Redirect_PC)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [31:0] ccr;
        logic        redir;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state: CCR byte and the return stack as a plain queue.
    logic [7:0]  m_ccr = 8'h00;
    logic [31:0] m_stack[$];

    // Monitor's view of what the DUT should currently be showing.
    logic [31:0] committed = 32'h0;
    logic        exp_rv = 1'b0;
    logic [31:0] exp_pc = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Flags vector f = {INR, Z, V, N, C}, matching CCR[4:0].
    task automatic model_op(input logic [31:0] op, input logic nop, input logic [4:0] f,
                            input logic [31:0] pcp, input logic [31:0] tgt,
                            output logic redir, output logic [31:0] pc);
        redir = 1'b0;
        pc    = 32'h0;
        if (nop) begin
            m_ccr[6] = 1'b1;
        end else begin
            if (!(op inside {32'd0, 32'd16, 32'd17, 32'd18, 32'd64, 32'd65}))
                m_ccr[4:0] = f;
            m_ccr[6] = 1'b0;
            case (op)
                32'd39: begin redir = f[3];  pc = tgt; end
                32'd40: begin redir = !f[3]; pc = tgt; end
                32'd41: begin redir = f[1];  pc = tgt; end
                32'd16, 32'd64: begin redir = 1'b1; pc = tgt; end
                32'd17, 32'd65: begin
                    if (m_stack.size() < RAS_DEPTH) m_stack.push_back(pcp);
                    else m_ccr[7] = 1'b1;
                    redir = 1'b1;
                    pc    = tgt;
                end
                32'd18: begin
                    if (m_stack.size() > 0) begin
                        pc    = m_stack.pop_back();
                        redir = 1'b1;
                    end else begin
                        m_ccr[7] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic drive_inputs(input logic [31:0] op, input logic nop, input logic [4:0] f,
                                input logic [31:0] pcp, input logic [31:0] tgt);
        ALU_Op        = op;
        NOP_FLAG      = nop;
        INR_FLAG      = f[4];
        ZERO_FLAG     = f[3];
        OVERFLOW_FLAG = f[2];
        NEGATIVE_FLAG = f[1];
        CARRY_FLAG    = f[0];
        PC_Plus       = pcp;
        Target        = tgt;
    endtask

    // Present one op for one cycle (DUT expected to be ready) and record the expectation.
    task automatic send_op(input logic [31:0] op, input logic nop, input logic [4:0] f,
                           input logic [31:0] pcp, input logic [31:0] tgt, output logic redir);
        exp_t        e;
        logic [31:0] pc;
        @(negedge Clock);
        Op_Valid = 1'b1;
        drive_inputs(op, nop, f, pcp, tgt);
        Redirect_Ready = 1'($urandom_range(0, 1));
        model_op(op, nop, f, pcp, tgt, redir, pc);
        e.ccr   = {24'h0, m_ccr};
        e.redir = redir;
        e.pc    = pc;
        exp_q.push_back(e);
    endtask

    // Stall the redirect for 'hold' cycles while offering junk ops, then accept it.
    task automatic finish_redirect(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge Clock);
            Redirect_Ready = 1'b0;
            Op_Valid       = 1'($urandom_range(0, 1));
            drive_inputs($urandom_range(0, 70), 1'($urandom_range(0, 1)),
                         5'($urandom), $urandom, $urandom);
        end
        @(negedge Clock);
        Redirect_Ready = 1'b1;
        Op_Valid       = 1'b0;
        @(posedge Clock);
        #1;
        check("ready_after_ack", {31'h0, Op_Ready}, 32'h1);
    endtask

    task automatic do_op(input logic [31:0] op, input logic nop, input logic [4:0] f,
                         input logic [31:0] pcp, input logic [31:0] tgt, input int hold);
        logic r;
        send_op(op, nop, f, pcp, tgt, r);
        if (r) finish_redirect(hold);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            Op_Valid       = 1'b0;
            Redirect_Ready = 1'b0;
        end
    endtask

    // Monitor: observe acceptance/handshake mid-cycle, compare just after the edge.
    initial begin : monitor
        logic acc;
        logic hs;
        logic rst_s;
        exp_t e;
        forever begin
            @(negedge Clock);
            #1;
            acc   = Op_Valid && Op_Ready && !Reset;
            hs    = Redirect_Valid && Redirect_Ready && !Reset;
            rst_s = Reset;
            @(posedge Clock);
            #1;
            if (rst_s) begin
                committed = 32'h0;
                exp_rv    = 1'b0;
            end else begin
                if (acc) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_accept actual=accepted required=no_accept op=%0d", ALU_Op);
                    end else begin
                        e = exp_q.pop_front();
                        check("ccr_after_op", CCR_Out, e.ccr);
                        check("redirect_valid_after_op", {31'h0, Redirect_Valid}, {31'h0, e.redir});
                        if (e.redir) check("redirect_pc", Redirect_PC, e.pc);
                        committed = e.ccr;
                        exp_rv    = e.redir;
                        exp_pc    = e.pc;
                    end
                end else begin
                    if (hs) exp_rv = 1'b0;
                    check("ccr_hold", CCR_Out, committed);
                    check("redirect_valid_hold", {31'h0, Redirect_Valid}, {31'h0, exp_rv});
                    if (exp_rv) check("redirect_pc_hold", Redirect_PC, exp_pc);
                end
                check("op_ready", {31'h0, Op_Ready}, {31'h0, !exp_rv});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        logic r;
        logic [31:0] ops [12];
        Reset          = 1'b1;
        Op_Valid       = 1'b0;
        Redirect_Ready = 1'b0;
        drive_inputs(32'h0, 1'b0, 5'h0, 32'h0, 32'h0);
        repeat (2) @(posedge Clock);
        #1;
        check("reset_ccr", CCR_Out, 32'h0);
        check("reset_rv", {31'h0, Redirect_Valid}, 32'h0);
        check("reset_pc", Redirect_PC, 32'h0);
        check("reset_ready", {31'h0, Op_Ready}, 32'h1);
        @(negedge Clock);
        Reset = 1'b0;

        // ADD with C=1 N=1.
        send_op(32'd1, 1'b0, 5'b00011, 32'h0, 32'h0, r);
        @(posedge Clock); #1;
        check("add_ccr", CCR_Out, 32'h03);
        check("add_no_redirect", {31'h0, Redirect_Valid}, 32'h0);

        // BEQ taken, redirect held for three cycles.
        send_op(32'd39, 1'b0, 5'b01000, 32'h0, 32'h40, r);
        @(posedge Clock); #1;
        check("beq_rv", {31'h0, Redirect_Valid}, 32'h1);
        check("beq_pc", Redirect_PC, 32'h40);
        check("beq_ready", {31'h0, Op_Ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            Redirect_Ready = 1'b0;
            Op_Valid       = 1'b1;
            @(posedge Clock); #1;
            check("beq_hold_rv", {31'h0, Redirect_Valid}, 32'h1);
            check("beq_hold_pc", Redirect_PC, 32'h40);
        end
        finish_redirect(0);

        // BNE with Z=1 is not taken; NOP with all flags set only marks bit 6.
        send_op(32'd40, 1'b0, 5'b01000, 32'h0, 32'h99, r);
        @(posedge Clock); #1;
        check("bne_no_redirect", {31'h0, Redirect_Valid}, 32'h0);
        send_op(32'd5, 1'b1, 5'b11111, 32'h0, 32'h0, r);
        @(posedge Clock); #1;
        check("nop_ccr", CCR_Out, 32'h48);

        // JSR then RTS round trip, then RTS on an empty stack.
        do_op(32'd17, 1'b0, 5'h1f, 32'h10, 32'h80, 1);
        send_op(32'd18, 1'b0, 5'h0, 32'h0, 32'h0, r);
        @(posedge Clock); #1;
        check("rts_pc", Redirect_PC, 32'h10);
        finish_redirect(2);
        send_op(32'd18, 1'b0, 5'h0, 32'h0, 32'h77, r);
        @(posedge Clock); #1;
        check("rts_empty_no_redirect", {31'h0, Redirect_Valid}, 32'h0);
        check("rts_empty_stkerr", {31'h0, CCR_Out[7]}, 32'h1);

        // RAS_DEPTH+1 calls: the last push overflows but still redirects.
        for (int i = 0; i <= RAS_DEPTH; i++) begin
            send_op(32'd65, 1'b0, 5'h0, 32'h100 + 32'(i), 32'h200 + 32'(i), r);
            if (i == RAS_DEPTH) begin
                @(posedge Clock); #1;
                check("bsr_full_redirect", {31'h0, Redirect_Valid}, 32'h1);
                check("bsr_full_pc", Redirect_PC, 32'h200 + 32'(RAS_DEPTH));
                check("bsr_full_stkerr", {31'h0, CCR_Out[7]}, 32'h1);
            end
            finish_redirect($urandom_range(0, 2));
        end

        // Reset while a redirect is pending.
        send_op(32'd17, 1'b0, 5'h0, 32'h1234, 32'h5678, r);
        @(negedge Clock);
        Reset          = 1'b1;
        Op_Valid       = 1'b0;
        Redirect_Ready = 1'b0;
        @(posedge Clock); #1;
        check("rst_mid_rv", {31'h0, Redirect_Valid}, 32'h0);
        check("rst_mid_ccr", CCR_Out, 32'h0);
        check("rst_mid_ready", {31'h0, Op_Ready}, 32'h1);
        check("rst_mid_pc", Redirect_PC, 32'h0);
        @(negedge Clock);
        Reset = 1'b0;
        m_ccr = 8'h00;
        m_stack.delete();
        send_op(32'd18, 1'b0, 5'h0, 32'h0, 32'h0, r);
        @(posedge Clock); #1;
        check("rst_stack_empty", CCR_Out, 32'h80);

        // Randomised mix of data and control ops.
        ops = '{32'd0, 32'd1, 32'd7, 32'd16, 32'd17, 32'd18, 32'd39,
                32'd40, 32'd41, 32'd64, 32'd65, 32'd100};
        for (int n = 0; n < 400; n++) begin
            logic [31:0] op;
            op = ops[$urandom_range(0, 11)];
            if (op == 32'd100) op = $urandom_range(0, 127);
            do_op(op, ($urandom_range(0, 7) == 0), 5'($urandom), $urandom, $urandom,
                  $urandom_range(0, 3));
        end

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
